sn74190_bcd_counter: RTL and testbench
======================================

// Module: sn74190_bcd_counter
// PURPOSE
//  Synchronous up/down decade counter with parallel load, count enables and ripple carry.
//  Sits directly upstream of the SN74145 decoder: o_qa..o_qd drive its i_a..i_d.
//  Generates the BCD sequence the decoder turns into one-of-ten lines.
//  Parallel load can inject invalid codes 10-15, so the decoder's all-off case is exercised in-system.
// PARAMETERS
//  MODULUS      10  count length, legal range 2..16; counts 0..MODULUS-1
//  RESET_VALUE  0   count value forced by i_n_rst, must be < MODULUS
// PORTS
//  i_clk      in   1  single clock, all state updates on rising edge
//  i_n_rst    in   1  asynchronous, active-low reset
//  i_n_clr    in   1  synchronous clear to 0, active-low
//  i_n_load   in   1  synchronous parallel load, active-low
//  i_load_a   in   1  load data bit 0 (LSB)
//  i_load_b   in   1  load data bit 1
//  i_load_c   in   1  load data bit 2
//  i_load_d   in   1  load data bit 3 (MSB)
//  i_enp      in   1  count enable P (local)
//  i_ent      in   1  count enable T (cascade), also gates o_rco
//  i_up       in   1  direction: 1 = up, 0 = down
//  o_qa       out  1  count bit 0 -> SN74145 i_a
//  o_qb       out  1  count bit 1 -> SN74145 i_b
//  o_qc       out  1  count bit 2 -> SN74145 i_c
//  o_qd       out  1  count bit 3 -> SN74145 i_d
//  o_tc       out  1  terminal count: up and q==MODULUS-1, or down and q==0
//  o_rco      out  1  ripple carry = o_tc & i_ent, feeds next stage's i_ent
//  o_valid    out  1  1 when q < MODULUS (code the decoder maps to a line)
// BEHAVIOUR
//  - State: 4-bit register q; o_qd..o_qa = q[3:0]. Registered outputs are glitch-free.
//  - o_tc, o_rco and o_valid are combinational from q, i_up and i_ent (zero latency).
//  - Reset: i_n_rst low clears immediately and asynchronously. q = RESET_VALUE, so o_valid = 1.
//    o_tc and o_rco follow their equations. Reset release takes effect on the next rising edge.
//  - Per-edge priority (highest first):
//      1. i_n_clr = 0: q <= 0
//      2. i_n_load = 0: q <= {d,c,b,a}; any value 0..15 is accepted as-is
//      3. i_enp & i_ent: count
//      4. otherwise: hold
//    Load and clear ignore i_enp, i_ent and i_up.
//  - Count up: if q >= MODULUS-1 then q <= 0, else q <= q+1. An invalid value wraps to 0 in one step.
//  - Count down: if q == 0 or q >= MODULUS then q <= MODULUS-1, else q <= q-1.
//  - One-cycle latency from an enable, load or clear edge to the new q.
//  - o_tc depends on direction. Changing i_up mid-count takes effect on the next edge with no state loss.
//  - Cascade rule: stage N+1 i_ent = stage N o_rco, with i_enp shared.
//    The carry is combinational, so a chain advances in the same edge.
//  - Direction change while o_tc = 1 recomputes o_tc immediately; no spurious count results.
//  - Asserting i_n_rst mid-count overrides every input. Load or clear held across reset release
//    apply on the first edge after release.
//  - No internal FSM beyond the counter. State space is q in 0..15, with next state per the rules above.
// TESTING
//  1. Reset low, then high; enp = ent = up = 1 for 10 edges
//     -> q 0,1..9,0; o_tc = o_rco = 1 only while q = 9.
//  2. up = 0 from q = 0 -> q 9,8..0,9; o_tc = 1 at q = 0. With ent = 0: o_rco = 0 and q holds.
//  3. n_load = 0 with d = 0111 -> q = 7 next edge. Then enp = 0 for 5 edges -> q stays 7.
//  4. Load 1100 -> q = 12, o_valid = 0 (SN74145 all outputs off).
//     Next up count -> q = 0; next down count from 12 -> q = 9.
//  5. Assert n_clr and n_load together with d = 0101 -> q = 0 (clear wins).
//     Drop i_n_rst mid-count at q = 6 -> q = 0 asynchronously, before the next edge.
//  6. Two stages cascaded, 100 up edges from 00 -> 99 -> 00.
//     The tens stage increments only on edges where the units stage has q = 9.

Source files
------------

// File: rtl/sn74190_bcd_counter_if.sv
// Control and count-output bundle for one SN74190-style decade counter stage.
// Pure wiring, no latency.
// No backpressure; outputs are level signals sampled by the consumer.
interface sn74190_bcd_counter_if;
  logic i_n_clr;
  logic i_n_load;
  logic i_load_a;
  logic i_load_b;
  logic i_load_c;
  logic i_load_d;
  logic i_enp;
  logic i_ent;
  logic i_up;
  logic o_qa;
  logic o_qb;
  logic o_qc;
  logic o_qd;
  logic o_tc;
  logic o_rco;
  logic o_valid;

  // Driver side: controls the counter and observes its outputs.
  modport master (
    output i_n_clr, i_n_load, i_load_a, i_load_b, i_load_c, i_load_d,
           i_enp, i_ent, i_up,
    input  o_qa, o_qb, o_qc, o_qd, o_tc, o_rco, o_valid
  );

  // Counter side.
  modport slave (
    input  i_n_clr, i_n_load, i_load_a, i_load_b, i_load_c, i_load_d,
           i_enp, i_ent, i_up,
    output o_qa, o_qb, o_qc, o_qd, o_tc, o_rco, o_valid
  );
endinterface

// File: rtl/sn74190_bcd_counter.sv
// Synchronous up/down modulo-N counter with clear, parallel load and ripple carry.
// Latency: one edge from clear/load/enable to new q; tc/rco/valid are combinational.
// No backpressure; cascade by feeding o_rco into the next stage's i_ent.
module sn74190_bcd_counter #(
  parameter int MODULUS     = 10, // legal 2..16; counts 0..MODULUS-1
  parameter int RESET_VALUE = 0   // must be below MODULUS
) (
  input logic                   i_clk,
  input logic                   i_n_rst,
  sn74190_bcd_counter_if.slave  bus
);

  localparam logic [3:0] LAST_Q  = 4'(MODULUS - 1);
  localparam logic [3:0] RESET_Q = 4'(RESET_VALUE);
  localparam logic [4:0] MOD_W   = 5'(MODULUS);

  logic [3:0] q;
  logic [3:0] q_nxt;
  logic [3:0] load_dat;

  assign load_dat = {bus.i_load_d, bus.i_load_c, bus.i_load_b, bus.i_load_a};

  // Next count: clear beats load beats count; loaded codes are taken verbatim,
  // and out-of-range codes recover to 0 (up) or MODULUS-1 (down) in one step.
  always_comb begin
    q_nxt = q;
    if (!bus.i_n_clr) begin
      q_nxt = 4'd0;
    end else if (!bus.i_n_load) begin
      q_nxt = load_dat;
    end else if (bus.i_enp && bus.i_ent) begin
      if (bus.i_up) begin
        q_nxt = (q >= LAST_Q) ? 4'd0 : q + 4'd1;
      end else begin
        q_nxt = ((q == 4'd0) || (q > LAST_Q)) ? LAST_Q : q - 4'd1;
      end
    end
  end

  // Count register; reset acts immediately without waiting for a clock.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      q <= RESET_Q;
    end else begin
      q <= q_nxt;
    end
  end

  assign bus.o_qa = q[0];
  assign bus.o_qb = q[1];
  assign bus.o_qc = q[2];
  assign bus.o_qd = q[3];

  // Terminal count follows the current direction so a direction flip is seen at once.
  assign bus.o_tc    = bus.i_up ? (q == LAST_Q) : (q == 4'd0);
  assign bus.o_rco   = bus.o_tc & bus.i_ent;
  assign bus.o_valid = ({1'b0, q} < MOD_W);

endmodule

// File: tb/tb_sn74190_bcd_counter.sv
module tb_sn74190_bcd_counter;

  localparam int M = 10;

  typedef struct {
    int q0;
    int tc0;
    int rco0;
    int vld0;
    int q1;
    int tc1;
    int rco1;
    int vld1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic n_clr, n_load, enp, ent, up;
  logic [3:0] d;
  logic t_n_clr, t_n_load;
  logic [3:0] t_d;

  int checks = 0;
  int failures = 0;
  int m_q0, m_q1;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sn74190_bcd_counter_if u_if ();
  sn74190_bcd_counter_if t_if ();

  // Units stage
  assign u_if.i_n_clr  = n_clr;
  assign u_if.i_n_load = n_load;
  assign u_if.i_load_a = d[0];
  assign u_if.i_load_b = d[1];
  assign u_if.i_load_c = d[2];
  assign u_if.i_load_d = d[3];
  assign u_if.i_enp    = enp;
  assign u_if.i_ent    = ent;
  assign u_if.i_up     = up;
  // Tens stage, cascaded from the units carry
  assign t_if.i_n_clr  = t_n_clr;
  assign t_if.i_n_load = t_n_load;
  assign t_if.i_load_a = t_d[0];
  assign t_if.i_load_b = t_d[1];
  assign t_if.i_load_c = t_d[2];
  assign t_if.i_load_d = t_d[3];
  assign t_if.i_enp    = enp;
  assign t_if.i_ent    = u_if.o_rco;
  assign t_if.i_up     = up;

  sn74190_bcd_counter u_units (.i_clk(clk), .i_n_rst(rst_n), .bus(u_if));
  sn74190_bcd_counter u_tens  (.i_clk(clk), .i_n_rst(rst_n), .bus(t_if));

  function automatic int q_of(input logic a, input logic b, input logic c, input logic dd);
    return int'({dd, c, b, a});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  function automatic int ref_tc(input int q, input bit u);
    return u ? int'(q == M - 1) : int'(q == 0);
  endfunction

  function automatic int ref_next(input int q, input bit c_n, input bit l_n, input int dv,
                                  input bit en, input bit u);
    if (!c_n) return 0;
    if (!l_n) return dv;
    if (!en) return q;
    if (u) return (q < M - 1) ? q + 1 : 0;
    return (q > 0 && q < M) ? q - 1 : M - 1;
  endfunction

  // Predict one clock edge with the inputs currently applied and queue the result.
  task automatic cycle();
    exp_t e;
    int rco0_pre;
    rco0_pre = ref_tc(m_q0, up) & int'(ent);
    if (!rst_n) begin
      m_q0 = 0;
      m_q1 = 0;
    end else begin
      m_q1 = ref_next(m_q1, t_n_clr, t_n_load, int'(t_d), enp && (rco0_pre != 0), up);
      m_q0 = ref_next(m_q0, n_clr, n_load, int'(d), enp && ent, up);
    end
    e.q0   = m_q0;
    e.tc0  = ref_tc(m_q0, up);
    e.rco0 = e.tc0 & int'(ent);
    e.vld0 = int'(m_q0 < M);
    e.q1   = m_q1;
    e.tc1  = ref_tc(m_q1, up);
    e.rco1 = e.tc1 & e.rco0;
    e.vld1 = int'(m_q1 < M);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drive(input bit c, input bit l, input int dv, input bit p, input bit t,
                       input bit u, input int n);
    n_clr = c; n_load = l; d = 4'(dv); enp = p; ent = t; up = u;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_now(input string tag);
    chk({tag, "_q0"},  q_of(u_if.o_qa, u_if.o_qb, u_if.o_qc, u_if.o_qd), m_q0);
    chk({tag, "_q1"},  q_of(t_if.o_qa, t_if.o_qb, t_if.o_qc, t_if.o_qd), m_q1);
    chk({tag, "_tc0"}, int'(u_if.o_tc), ref_tc(m_q0, up));
    chk({tag, "_vld0"}, int'(u_if.o_valid), int'(m_q0 < M));
  endtask

  // Monitor: compare every post-edge DUT state against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("q0",   q_of(u_if.o_qa, u_if.o_qb, u_if.o_qc, u_if.o_qd), e.q0);
        chk("tc0",  int'(u_if.o_tc), e.tc0);
        chk("rco0", int'(u_if.o_rco), e.rco0);
        chk("vld0", int'(u_if.o_valid), e.vld0);
        chk("q1",   q_of(t_if.o_qa, t_if.o_qb, t_if.o_qc, t_if.o_qd), e.q1);
        chk("tc1",  int'(t_if.o_tc), e.tc1);
        chk("rco1", int'(t_if.o_rco), e.rco1);
        chk("vld1", int'(t_if.o_valid), e.vld1);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected done by %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    n_clr = 1'b1; n_load = 1'b1; d = 4'd0; enp = 1'b0; ent = 1'b0; up = 1'b1;
    t_n_clr = 1'b1; t_n_load = 1'b1; t_d = 4'd0;
    m_q0 = 0; m_q1 = 0;
    #1;
    check_now("reset");
    chk("reset_rco0", int'(u_if.o_rco), 0);

    // Release reset at a falling edge; it takes effect from the next rising edge.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: count up through a full decade; tens steps once on the wrap.
    drive(1, 1, 0, 1, 1, 1, 10);
    // 2: count down from 0 through 9..0 and back to 9; then ent low holds.
    drive(1, 1, 0, 1, 1, 0, 11);
    drive(1, 1, 0, 1, 0, 0, 3);
    // 3: load 7, then hold with enp low.
    drive(1, 0, 7, 1, 1, 1, 1);
    drive(1, 1, 0, 0, 1, 1, 5);
    // 4: invalid code 12 recovers to 0 going up and to 9 going down.
    drive(1, 0, 12, 0, 0, 1, 1);
    drive(1, 1, 0, 1, 1, 1, 1);
    drive(1, 0, 12, 0, 0, 0, 1);
    drive(1, 1, 0, 1, 1, 0, 1);
    // Direction flip at terminal count is visible immediately.
    drive(1, 1, 0, 1, 1, 1, 1);
    up = 1'b0;
    #1;
    chk("flip_tc0", int'(u_if.o_tc), ref_tc(m_q0, 1'b0));
    up = 1'b1;
    #1;
    chk("flip_back_tc0", int'(u_if.o_tc), ref_tc(m_q0, 1'b1));
    @(negedge clk);
    // Keep the model honest about the edge that passed during the flip.
    // (inputs were count-up, so predict it retroactively against the DUT)
    m_q1 = ref_next(m_q1, t_n_clr, t_n_load, int'(t_d),
                    enp && (ref_tc(m_q0, up) & int'(ent)) != 0, up);
    m_q0 = ref_next(m_q0, n_clr, n_load, int'(d), enp && ent, up);
    check_now("after_flip");

    // 5: clear beats load; count to 6; async reset lands before the next edge.
    drive(0, 0, 5, 1, 1, 1, 1);
    drive(1, 1, 0, 1, 1, 1, 6);
    #2;
    rst_n = 1'b0;
    m_q0 = 0;
    m_q1 = 0;
    #1;
    check_now("async_rst");
    drive(1, 0, 3, 1, 1, 1, 1);
    rst_n = 1'b1;
    // Load held across release applies on the first edge after it.
    drive(1, 0, 3, 1, 1, 1, 1);

    // 6: two-stage cascade, 100 edges from 00 back to 00.
    t_n_clr = 1'b0;
    drive(0, 1, 0, 1, 1, 1, 1);
    t_n_clr = 1'b1;
    drive(1, 1, 0, 1, 1, 1, 99);
    check_now("cascade_99");
    drive(1, 1, 0, 1, 1, 1, 1);
    check_now("cascade_00");

    // Random mix of all controls on both stages.
    for (int i = 0; i < 300; i++) begin
      t_n_clr  = ($urandom_range(31) != 0);
      t_n_load = ($urandom_range(15) != 0);
      t_d      = 4'($urandom_range(15));
      drive($urandom_range(15) != 0, $urandom_range(7) != 0, $urandom_range(15),
            $urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(1) != 0, 1);
    end
    t_n_clr = 1'b1; t_n_load = 1'b1;

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
